float_add_arbiter: RTL and testbench
====================================

Name: float_add_arbiter

Overview:
- Shares one `float_add` instance among NUM_REQ requesters using a round-robin scheme.
- Each requester has a valid/ready interface. The block drives the adder operands and tracks which requester owns each in-flight operation.
- Results return on one shared valid/ready result stream tagged with the requester id. A credit-protected result FIFO absorbs downstream backpressure.
- Sits between the compute clients and the single adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- EXPONENT_WIDTH, 8, float exponent bits.
- MANTISSA_WIDTH, 23, float stored mantissa bits.
- ADD_LATENCY, 2, cycles from operand presentation to result on add_c (`float_add` registers input and output).
- RES_FIFO_DEPTH, 4, result FIFO entries; must be >= ADD_LATENCY.
- W (local) = 1+EXPONENT_WIDTH+MANTISSA_WIDTH. IDW (local) = max(1,$clog2(NUM_REQ)).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NUM_REQ*W  operand B, same packing.
- add_a  out  W  adder operand A (to `float_add` in_a).
- add_b  out  W  adder operand B (to `float_add` in_b).
- add_c  in  W  adder result (from `float_add` out_c).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  W  sum.
- res_id  out  IDW  requester index that owns res_data.

Behaviour:
- **Credits.** credits = RES_FIFO_DEPTH − fifo_count − inflight_count. issue_ok = (credits > 0).
- **Arbitration (combinational).**
  - Grant goes to the first requester with req_valid=1, searching upward from rr_ptr with wrap-around.
  - req_ready[g] = 1 only when issue_ok and g is granted; all other bits are 0.
  - Handshake = req_valid[g] & req_ready[g].
- **Pointer update.** On a handshake, rr_ptr <= (g+1) mod NUM_REQ on the next edge. Without a handshake, rr_ptr holds.
- **Operand drive.**
  - add_a/add_b = req_a/req_b slice of g when a handshake occurs; otherwise 0.
  - Zero operands are harmless: their results are discarded by tag.
- **Tag pipeline.**
  - Shift register of ADD_LATENCY stages, each {valid, id}.
  - Stage 0 loads {handshake, g} every cycle.
  - inflight_count = number of valid stages.
- **Result capture.** When the last stage is valid, {id, add_c} is pushed into the result FIFO in that cycle. Results therefore appear exactly ADD_LATENCY cycles after the handshake, in issue order.
- **Result FIFO.**
  - res_valid = !empty. res_data/res_id = head entry. Pop on res_valid & res_ready.
  - Simultaneous push and pop are allowed; count is unchanged.
  - Push into a full FIFO cannot occur (guaranteed by credits). Add an assertion for this.
  - Pointers wrap modulo RES_FIFO_DEPTH.
- **Throughput.** One issue per cycle while credits are available. With res_ready held high, sustained throughput is 1 operation per cycle.
- **Reset.**
  - rr_ptr=0, tag pipeline cleared, FIFO empty, res_valid=0, and req_ready=0 while rst=1.
  - Reset mid-operation discards in-flight and buffered results.
  - The adder's own registers are not reset; their outputs are ignored because the tags are cleared.
- **Single requester.** NUM_REQ=1 degenerates to a pass-through with credit flow control.

Optional Feature:
- Macro: FLOAT_ADD_ARB_STATS_EN.
- When defined:
  - Adds output grant_count (NUM_REQ*16): per-requester 16-bit saturating counter of handshakes.
  - Adds output stall_count (16): saturating count of cycles with any req_valid high but issue_ok=0.
  - All counters clear on rst.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package float_add_pkg holds:
  - the float struct typedef (sign, exponent, mantissa) parameterised by the 8/23 defaults;
  - the constant FLOAT_ADD_LATENCY=2;
  - a function rr_pick(valid, ptr) returning the grant index.
- One sub-module: float_add_res_fifo, a synchronous FIFO with width W+IDW, parameter depth, and outputs count/empty/full.

Test Plan:
- **Single issue.** Req0 a=0x3F800000 (1.0), b=0x40000000 (2.0) -> handshake cycle t; FIFO push at t+2; res_valid at t+3 with res_data=0x40400000, res_id=0.
- **Round-robin.** All four req_valid held, res_ready=1, rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; results return in the same id order.
- **Backpressure.** res_ready=0 while req0 streams 0x3F000000+0x3F000000 -> exactly 4 accepts, then req_ready=0. res_ready=1 -> 4 results of 0x3F800000, then issue resumes.
- **Simultaneous push/pop.** FIFO at 3 entries, push and pop in the same cycle -> count stays 3 and ordering is preserved.
- **Reset mid-operation.** rst for 1 cycle with 2 operations in flight and 1 buffered -> res_valid=0 after reset; no stale results emerge; rr_ptr=0.
- **Stats (with FLOAT_ADD_ARB_STATS_EN).** 10 req1 handshakes -> grant_count[1]=10; stall_count counts each blocked cycle.

Source files
------------

// File: rtl/float_add_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | float_add_pkg: shared float types and round-robin pick helper     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package float_add_pkg;

  localparam int c_FLOAT_EXP_W     = 8;
  localparam int c_FLOAT_MAN_W     = 23;
  localparam int FLOAT_ADD_LATENCY = 2;
  localparam int c_RR_MAX_REQ      = 16;

  typedef struct packed {
    logic                     sign;
    logic [c_FLOAT_EXP_W-1:0] exponent;
    logic [c_FLOAT_MAN_W-1:0] mantissa;
  } float_t;

  // Unused upper request bits must be zero, so a mod-16 search from ptr
  // visits live requesters in the same order as a mod-NUM_REQ search.
  function automatic logic [3:0] rr_pick(input logic [c_RR_MAX_REQ-1:0] valid,
                                         input logic [3:0]              ptr);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int k = c_RR_MAX_REQ - 1; k >= 0; k--) begin
      idx = ptr + 4'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/float_add_res_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | float_add_res_fifo: synchronous result FIFO {id, sum}             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module float_add_res_fifo #(
  parameter int  WIDTH  = 34,
  parameter int  DEPTH  = 4,
  localparam int c_CNTW = $clog2(DEPTH + 1),
  localparam int c_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic [c_CNTW-1:0] count,
  output logic              empty,
  output logic              full
);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [c_PTRW-1:0] r_wr_ptr;
  logic [c_PTRW-1:0] r_rd_ptr;
  logic [c_CNTW-1:0] r_count;
  logic              w_pop;

  function automatic logic [c_PTRW-1:0] ptr_inc(input logic [c_PTRW-1:0] p);
    return (p == c_PTRW'(DEPTH - 1)) ? '0 : p + c_PTRW'(1);
  endfunction

  assign w_pop    = pop & ~empty;
  assign empty    = (r_count == '0);
  assign full     = (r_count == c_CNTW'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({push, w_pop})
        2'b10:   r_count <= r_count + c_CNTW'(1);
        2'b01:   r_count <= r_count - c_CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/float_add_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | float_add_arbiter: round-robin share of one float_add, tagged     |
// | credit-protected results. Option: FLOAT_ADD_ARB_STATS_EN. Rev 1.0 |
// +------------------------------------------------------------------+
module float_add_arbiter
  import float_add_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  EXPONENT_WIDTH = 8,
  parameter int  MANTISSA_WIDTH = 23,
  parameter int  ADD_LATENCY    = FLOAT_ADD_LATENCY,
  parameter int  RES_FIFO_DEPTH = 4,
  localparam int c_W            = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH,
  localparam int c_IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*c_W-1:0] req_a,
  input  logic [NUM_REQ*c_W-1:0] req_b,
  output logic [c_W-1:0]         add_a,
  output logic [c_W-1:0]         add_b,
  input  logic [c_W-1:0]         add_c,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [c_W-1:0]         res_data,
  output logic [c_IDW-1:0]       res_id
`ifdef FLOAT_ADD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  grant_count,
  output logic [15:0]            stall_count
`endif
);

  localparam int c_FW   = c_IDW + c_W;
  localparam int c_CNTW = $clog2(RES_FIFO_DEPTH + 1);

  logic [c_IDW-1:0]       r_rr_ptr;
  logic [ADD_LATENCY-1:0] r_tag_v;
  logic [c_IDW-1:0]       r_tag_id [ADD_LATENCY];

  logic [c_IDW-1:0]  w_gid;
  logic              w_issue_ok;
  logic              w_hs;
  logic [31:0]       w_inflight;
  logic [31:0]       w_used;
  logic              w_push;
  logic              w_pop;
  logic [c_CNTW-1:0] w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [c_FW-1:0]   w_head;

  // Credits: every in-flight op already owns a FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < ADD_LATENCY; i++) w_inflight = w_inflight + 32'(r_tag_v[i]);
    w_used = w_inflight + 32'(w_fifo_count);
  end

  assign w_issue_ok = !rst && (w_used < 32'(RES_FIFO_DEPTH));
  assign w_gid      = c_IDW'(rr_pick(16'(req_valid), 4'(r_rr_ptr)));
  assign w_hs       = w_issue_ok & req_valid[w_gid];

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (w_hs) begin
      req_ready[w_gid] = 1'b1;
      add_a            = req_a[w_gid*c_W +: c_W];
      add_b            = req_b[w_gid*c_W +: c_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_gid == c_IDW'(NUM_REQ - 1)) ? '0 : w_gid + c_IDW'(1);
    end
  end

  // Tags mirror the adder pipeline; a clear here discards any result in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < ADD_LATENCY; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= w_hs;
      r_tag_id[0] <= w_gid;
      for (int i = 1; i < ADD_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign w_push = r_tag_v[ADD_LATENCY-1];
  assign w_pop  = res_valid & res_ready;

  float_add_res_fifo #(
    .WIDTH (c_FW),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_tag_id[ADD_LATENCY-1], add_c}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_fifo_count),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full)
  );

  assign res_valid = !w_fifo_empty && !rst;
  assign res_id    = w_head[c_FW-1 -: c_IDW];
  assign res_data  = w_head[c_W-1:0];

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_fifo_full));

`ifdef FLOAT_ADD_ARB_STATS_EN
  logic [15:0] r_stall;

  generate
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_hs && (w_gid == c_IDW'(r)) && (r_cnt != 16'hFFFF)) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign grant_count[r*16 +: 16] = r_cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if ((|req_valid) && !w_issue_ok && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_count = r_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_float_add_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_float_add_arbiter: directed table, corner sequences, random    |
// | traffic against a queue-based reference model. Rev 1.0            |
// +------------------------------------------------------------------+
module tb_float_add_arbiter;
  import float_add_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = FLOAT_ADD_LATENCY;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_c;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
`ifdef FLOAT_ADD_ARB_STATS_EN
  logic [N*16-1:0] grant_count;
  logic [15:0]     stall_count;
`endif

  always #5 clk = ~clk;

  float_add_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c     (add_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
`ifdef FLOAT_ADD_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .stall_count (stall_count)
`endif
  );

  // ---------------- float helpers (denormals flush to zero) ----------------
  function automatic real f2r(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic        s;
    real         v;
    int          e;
    logic [22:0] m;
    if (x == 0.0) return 32'd0;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    m = 23'($rtoi((v - 1.0) * 8388608.0));
    return {s, 8'(e + 127), m};
  endfunction

  // Adder stand-in: registered inputs and output, two cycles of latency.
  logic [31:0] st_a, st_b, st_c;
  always @(posedge clk) begin
    st_a <= add_a;
    st_b <= add_b;
    st_c <= r2f(f2r(st_a) + f2r(st_b));
  end
  assign add_c = st_c;

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int tcyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, tcyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] d;
    int          t;
  } ent_t;

  ent_t m_infl[$];
  ent_t m_fifo[$];
  ent_t hs_log[$];
  ent_t pop_log[$];
  int   m_ptr = 0;
  int   m_g, m_cred, m_idx;
  logic [N-1:0] m_rdy;
  logic [31:0]  m_ea, m_eb;
`ifdef FLOAT_ADD_ARB_STATS_EN
  int exp_gc[N];
  int exp_stall = 0;
`endif

  always @(posedge clk) tcyc = tcyc + 1;

  // Reference model: queues of owed results, checked every cycle on negedge.
  always @(negedge clk) begin
    if (rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      chk("res_valid_in_reset", 64'(res_valid), 64'd0);
      m_infl.delete();
      m_fifo.delete();
      m_ptr = 0;
`ifdef FLOAT_ADD_ARB_STATS_EN
      for (int i = 0; i < N; i++) exp_gc[i] = 0;
      exp_stall = 0;
`endif
    end else begin
      m_cred = D - m_fifo.size() - m_infl.size();
      m_g = -1;
      if (m_cred > 0) begin
        for (int k = 0; k < N; k++) begin
          m_idx = (m_ptr + k) % N;
          if (req_valid[m_idx]) begin m_g = m_idx; break; end
        end
      end
      m_rdy = '0; m_ea = '0; m_eb = '0;
      if (m_g >= 0) begin
        m_rdy[m_g] = 1'b1;
        m_ea = req_a[m_g*W +: W];
        m_eb = req_b[m_g*W +: W];
      end
      chk("req_ready", 64'(req_ready), 64'(m_rdy));
      chk("add_a", 64'(add_a), 64'(m_ea));
      chk("add_b", 64'(add_b), 64'(m_eb));
      chk("res_valid", 64'(res_valid), 64'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
        chk("res_data", 64'(res_data), 64'(m_fifo[0].d));
        chk("res_id", 64'(res_id), 64'(m_fifo[0].id));
      end
`ifdef FLOAT_ADD_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("grant_count", 64'(grant_count[i*16 +: 16]), 64'(exp_gc[i]));
      chk("stall_count", 64'(stall_count), 64'(exp_stall));
      if (m_g >= 0) exp_gc[m_g]++;
      if ((|req_valid) && m_cred <= 0) exp_stall++;
`endif
      for (int k = 0; k < N; k++)
        if (req_valid[k] && req_ready[k]) hs_log.push_back('{k, 32'd0, tcyc});
      if (res_valid && res_ready) pop_log.push_back('{int'(res_id), res_data, tcyc});
      // advance model across the coming edge
      if (m_fifo.size() > 0 && res_ready) void'(m_fifo.pop_front());
      if (m_infl.size() > 0 && m_infl[0].t == tcyc - L) m_fifo.push_back(m_infl.pop_front());
      if (m_g >= 0) begin
        m_infl.push_back('{m_g, r2f(f2r(m_ea) + f2r(m_eb)), tcyc});
        m_ptr = (m_g + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  task automatic issue_one(input int r, input logic [31:0] a, input logic [31:0] b, output int t);
    set_op(r, a, b);
    req_valid[r] = 1'b1;
    t = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin t = tcyc; break; end
    end
    chk("issue_handshake", 64'(t >= 0), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, n0, np0, k;
    ent_t e;

    vecs[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    vecs[1] = '{32'h3F000000, 32'h3F000000, 32'h3F800000};
    vecs[2] = '{32'h40000000, 32'h40000000, 32'h40800000};
    vecs[3] = '{32'hBF800000, 32'h40400000, 32'h40000000};
    vecs[4] = '{32'h3FC00000, 32'h3E800000, 32'h3FE00000};
    vecs[5] = '{32'h41200000, 32'hC0A00000, 32'h40A00000};

    req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Table: single issues, result exactly three cycles after handshake.
    for (int i = 0; i < 6; i++) begin
      n0 = pop_log.size();
      issue_one(i % N, vecs[i].a, vecs[i].b, t);
      k = 0;
      while (pop_log.size() == n0 && k < 20) begin @(posedge clk); k++; end
      #1;
      chk("vec_result_seen", 64'(pop_log.size() > n0), 64'd1);
      if (pop_log.size() > n0) begin
        e = pop_log[n0];
        chk("vec_data", 64'(e.d), 64'(vecs[i].s));
        chk("vec_id", 64'(e.id), 64'(i % N));
        chk("vec_latency", 64'(e.t - t), 64'd3);
      end
    end

    // Round-robin with all requesters busy from rr_ptr = 0.
    rst = 1'b1; tick(1); rst = 1'b0;
    n0 = hs_log.size(); np0 = pop_log.size();
    for (int r = 0; r < N; r++) set_op(r, vecs[r].a, vecs[r].b);
    req_valid = '1;
    tick(8);
    req_valid = '0;
    tick(8);
    chk("rr_grant_count", 64'(hs_log.size() - n0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (n0 + i < hs_log.size()) begin
        chk("rr_grant_order", 64'(hs_log[n0+i].id), 64'(i % N));
        if (i > 0) chk("rr_back_to_back", 64'(hs_log[n0+i].t - hs_log[n0+i-1].t), 64'd1);
      end
      if (np0 + i < pop_log.size()) begin
        chk("rr_result_id", 64'(pop_log[np0+i].id), 64'(i % N));
        chk("rr_result_data", 64'(pop_log[np0+i].d), 64'(vecs[i % N].s));
      end
    end

    // Backpressure: four credits, then stall until results drain.
    res_ready = 1'b0;
    n0 = hs_log.size();
    set_op(0, 32'h3F000000, 32'h3F000000);
    req_valid[0] = 1'b1;
    tick(10);
    chk("bp_accepts", 64'(hs_log.size() - n0), 64'd4);
    @(negedge clk);
    chk("bp_ready_low", 64'(req_ready), 64'd0);
    tick(1);
    np0 = pop_log.size();
    res_ready = 1'b1;
    tick(8);
    chk("bp_results", 64'(pop_log.size() - np0 >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (np0 + i < pop_log.size()) chk("bp_data", 64'(pop_log[np0+i].d), 64'h3F800000);
    chk("bp_resumed", 64'(hs_log.size() - n0 > 4), 64'd1);
    req_valid = '0;
    tick(8);

    // Simultaneous push and pop with three entries buffered.
    res_ready = 1'b0;
    np0 = pop_log.size();
    for (int r = 0; r < 3; r++) issue_one(r, vecs[r].a, vecs[r].b, t);
    tick(3);
    issue_one(3, vecs[3].a, vecs[3].b, t);
    tick(1);
    res_ready = 1'b1;
    tick(1);
    res_ready = 1'b0;
    n0 = hs_log.size();
    set_op(0, vecs[4].a, vecs[4].b);
    req_valid[0] = 1'b1;
    tick(4);
    req_valid[0] = 1'b0;
    chk("pp_single_credit", 64'(hs_log.size() - n0), 64'd1);
    res_ready = 1'b1;
    tick(10);
    chk("pp_pop_count", 64'(pop_log.size() - np0), 64'd5);
    for (int i = 0; i < 5; i++)
      if (np0 + i < pop_log.size()) chk("pp_order", 64'(pop_log[np0+i].d), 64'(vecs[i].s));

    // Reset with two in flight and one buffered.
    res_ready = 1'b0;
    issue_one(0, vecs[0].a, vecs[0].b, t);
    tick(3);
    set_op(1, vecs[1].a, vecs[1].b);
    set_op(2, vecs[2].a, vecs[2].b);
    n0 = hs_log.size();
    req_valid = 4'b0110;
    tick(2);
    req_valid = '0;
    chk("rst_two_inflight", 64'(hs_log.size() - n0), 64'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    res_ready = 1'b1;
    np0 = pop_log.size();
    tick(8);
    chk("rst_no_stale", 64'(pop_log.size() - np0), 64'd0);
    n0 = hs_log.size();
    for (int r = 0; r < N; r++) set_op(r, vecs[r].a, vecs[r].b);
    req_valid = '1;
    tick(1);
    req_valid = '0;
    chk("rst_ptr_grant", 64'(hs_log.size() - n0), 64'd1);
    if (hs_log.size() > n0) chk("rst_ptr_zero", 64'(hs_log[n0].id), 64'd0);
    tick(6);

`ifdef FLOAT_ADD_ARB_STATS_EN
    rst = 1'b1; tick(1); rst = 1'b0;
    set_op(1, vecs[0].a, vecs[0].b);
    req_valid[1] = 1'b1;
    tick(10);
    req_valid[1] = 1'b0;
    tick(6);
    @(negedge clk);
    chk("stats_grant1", 64'(grant_count[16 +: 16]), 64'd10);
    chk("stats_no_stall", 64'(stall_count), 64'd0);
    tick(1);
    res_ready = 1'b0;
    req_valid[0] = 1'b1;
    tick(8);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("stats_stall", 64'(stall_count), 64'd4);
    tick(1);
    res_ready = 1'b1;
    tick(6);
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      for (int r = 0; r < N; r++)
        set_op(r, {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)},
                  {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)});
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    rst = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
